// File: rtl/shift_right_iter.sv
// Iterative right shifter (srl/sra) that consumes at most STEP bit positions per clock.
// Optional rotate-right mode is enabled by defining SHIFT_RIGHT_ROTATE_EN.
module shift_right_iter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     ctrl_start,
  input  logic                     ctrl_arith,
`ifdef SHIFT_RIGHT_ROTATE_EN
  input  logic                     ctrl_rotate,
`endif
  input  logic [WIDTH-1:0]         data_operandA,
  input  logic [$clog2(WIDTH)-1:0] ctrl_shiftamt,
  output logic [WIDTH-1:0]         data_result,
  output logic                     data_resultRDY,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(WIDTH);
  localparam int unsigned SW = $clog2(STEP) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  work, work_next, result_next, shifted;
  logic [AW-1:0]     rem, rem_next;
  logic              fill, fill_next;
  logic              last_step;
  logic [SW-1:0]     step_amt;
  logic [2*WIDTH-1:0] ext;
`ifdef SHIFT_RIGHT_ROTATE_EN
  logic              rot, rot_next;
`endif

  // One step of at most STEP positions; the upper half of ext supplies the vacated bits.
  always_comb begin
    last_step = ({1'b0, rem} <= (AW+1)'(STEP));
    step_amt  = last_step ? SW'(rem) : SW'(STEP);
`ifdef SHIFT_RIGHT_ROTATE_EN
    ext = rot ? {work, work} : {{WIDTH{fill}}, work};
`else
    ext = {{WIDTH{fill}}, work};
`endif
    shifted = WIDTH'(ext >> step_amt);
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a start in any state restarts the operation
  always_comb begin
    state_next = state;
    if (ctrl_start) begin
      state_next = (ctrl_shiftamt != '0) ? RUN : DONE;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     state_next = last_step ? DONE : RUN;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Next values for the datapath and registered outputs
  always_comb begin
    work_next = work;
    rem_next  = rem;
    fill_next = fill;
`ifdef SHIFT_RIGHT_ROTATE_EN
    rot_next  = rot;
`endif
    if (ctrl_start) begin
      work_next = data_operandA;
      rem_next  = ctrl_shiftamt;
      fill_next = data_operandA[WIDTH-1] & ctrl_arith;
`ifdef SHIFT_RIGHT_ROTATE_EN
      rot_next  = ctrl_rotate;
`endif
    end else if (state == RUN) begin
      work_next = shifted;
      rem_next  = rem - AW'(step_amt);
    end
    result_next = (state_next == DONE) ? work_next : data_result;
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work           <= '0;
      rem            <= '0;
      fill           <= 1'b0;
`ifdef SHIFT_RIGHT_ROTATE_EN
      rot            <= 1'b0;
`endif
      data_result    <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      work           <= work_next;
      rem            <= rem_next;
      fill           <= fill_next;
`ifdef SHIFT_RIGHT_ROTATE_EN
      rot            <= rot_next;
`endif
      data_result    <= result_next;
      data_resultRDY <= (state_next == DONE);
      busy           <= (state_next == RUN);
    end
  end

endmodule

// File: tb/tb_shift_right_iter.sv
// Randomized self-checking bench for shift_right_iter against an arithmetic reference model.
// Rotate checks are included when SHIFT_RIGHT_ROTATE_EN is defined.
module tb_shift_right_iter;

  localparam int W = 32;
  localparam int S = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          ctrl_start;
  logic          ctrl_arith;
  logic          ctrl_rotate;
  logic [W-1:0]  data_operandA;
  logic [4:0]    ctrl_shiftamt;
  logic [W-1:0]  data_result;
  logic          data_resultRDY;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_res;

  shift_right_iter #(.WIDTH(W), .STEP(S)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_arith     (ctrl_arith),
`ifdef SHIFT_RIGHT_ROTATE_EN
    .ctrl_rotate    (ctrl_rotate),
`endif
    .data_operandA  (data_operandA),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input int amt,
                                         input bit arith, input bit rot);
    logic [W-1:0] r;
    if (rot)        r = (a >> amt) | ((amt == 0) ? '0 : (a << (W - amt)));
    else if (arith) r = $signed(a) >>> amt;
    else            r = a >> amt;
    return r;
  endfunction

  // Scramble non-start inputs; they must be ignored.
  task automatic idle_inputs();
    ctrl_start    = 1'b0;
    ctrl_arith    = 1'($urandom_range(0, 1));
    ctrl_rotate   = 1'($urandom_range(0, 1));
    data_operandA = $urandom;
    ctrl_shiftamt = 5'($urandom_range(0, 31));
  endtask

  // Called just after a negedge; returns just after the negedge following the RDY cycle.
  task automatic do_op(input logic [W-1:0] a, input int amt, input bit arith, input bit rot,
                       input string tag);
    logic [W-1:0] exp;
    int lat, edges, busy_cnt;
    bit held_ok;
    exp = model(a, amt, arith, rot);
    lat = 1 + (amt + S - 1) / S;
    ctrl_start = 1'b1; ctrl_arith = arith; ctrl_rotate = rot;
    data_operandA = a; ctrl_shiftamt = 5'(amt);
    @(negedge clock);
    idle_inputs();
    edges = 1; busy_cnt = 0; held_ok = 1;
    while (!data_resultRDY && edges < 64) begin
      if (busy) busy_cnt++;
      if (data_result !== last_res) held_ok = 0;
      @(negedge clock);
      edges++;
    end
    check({tag, " latency"}, W'(edges), W'(lat));
    check({tag, " result"}, data_result, exp);
    check({tag, " busy cycles"}, W'(busy_cnt), W'(lat - 1));
    check({tag, " result held"}, W'(held_ok), W'(1));
    last_res = exp;
    @(negedge clock);
    check({tag, " rdy one cycle"}, W'(data_resultRDY), W'(0));
    check({tag, " idle busy"}, W'(busy), W'(0));
  endtask

  initial begin
    bit quiet;
    reset = 1'b1;
    last_res = '0;
    idle_inputs();
    repeat (2) @(negedge clock);
    check("reset result", data_result, '0);
    check("reset rdy", W'(data_resultRDY), W'(0));
    check("reset busy", W'(busy), W'(0));
    reset = 1'b0;
    @(negedge clock);

    do_op(32'h8000_0000, 31, 0, 0, "srl31");
    do_op(32'h8000_0000, 4, 1, 0, "sra4");
    do_op(32'h8000_0000, 4, 0, 0, "srl4");
    do_op(32'h1234_5678, 0, 1, 0, "amt0");
    do_op(32'h8765_4321, 31, 1, 0, "sra31neg");
    do_op(32'h8000_0000, 8, 1, 0, "sra8");
    do_op(32'h7FFF_FFFF, 9, 1, 0, "sra9pos");

    // Abort: restart after one RUN cycle; only the second operation completes.
    ctrl_start = 1'b1; ctrl_arith = 1'b0; ctrl_rotate = 1'b0;
    data_operandA = 32'hDEAD_BEEF; ctrl_shiftamt = 5'd24;
    @(negedge clock);
    idle_inputs();
    check("abort busy", W'(busy), W'(1));
    check("abort no rdy", W'(data_resultRDY), W'(0));
    do_op(32'h0000_0100, 8, 0, 0, "restart");

`ifdef SHIFT_RIGHT_ROTATE_EN
    do_op(32'h0000_0001, 1, 0, 1, "rot1");
    do_op(32'h1234_5678, 16, 1, 1, "rot16");
`endif

    for (int i = 0; i < 40; i++) begin
      bit rot;
`ifdef SHIFT_RIGHT_ROTATE_EN
      rot = 1'($urandom_range(0, 1));
`else
      rot = 1'b0;
`endif
      do_op($urandom, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), rot, "rand");
    end

    // Reset mid-RUN clears outputs at once and leaves no pending completion.
    ctrl_start = 1'b1; ctrl_arith = 1'b0; ctrl_rotate = 1'b0;
    data_operandA = 32'hFFFF_0000; ctrl_shiftamt = 5'd20;
    @(negedge clock);
    idle_inputs();
    @(negedge clock);
    check("pre-reset busy", W'(busy), W'(1));
    reset = 1'b1;
    #1;
    check("async reset result", data_result, '0);
    check("async reset rdy", W'(data_resultRDY), W'(0));
    check("async reset busy", W'(busy), W'(0));
    last_res = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    quiet = 1;
    repeat (8) begin
      @(negedge clock);
      if (data_resultRDY || busy || data_result !== '0) quiet = 0;
    end
    check("post-reset quiet", W'(quiet), W'(1));

    do_op(32'hF000_000F, 12, 1, 0, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
